// File: rtl/carry_select_subtractor_pipe_32bits_pkg.sv
// Shared constants, block partition helpers and the pipeline register type
// for the carry-select subtractor.
package csel_sub_pkg;

    localparam int WIDTH        = 32;
    localparam int BLOCK_AMOUNT = 4;
    localparam int BLOCKS [BLOCK_AMOUNT] = '{4, 10, 20, 32};

    function automatic int blk_lo(input int i);
        int lo;
        lo = 0;
        if (i > 0) lo = BLOCKS[i-1];
        return lo;
    endfunction

    function automatic int blk_w(input int i);
        return BLOCKS[i] - blk_lo(i);
    endfunction

    // Operand bits are zeroed once their block has been resolved.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] d;
        logic             carry;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] nb_rem;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

endpackage

// File: rtl/carry_select_subtractor_pipe_32bits_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface carry_select_subtractor_pipe_32bits_if;
    import csel_sub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Z;
    logic             V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, Z, V
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, Z, V
    );

endinterface

// File: rtl/carry_select_subtractor_pipe_32bits_csel_block.sv
// One carry-select block: both carry-in outcomes precomputed, picked by sel.
module csel_block #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] s_c0, s_c1;
    logic         co_c0, co_c1;

    ripple_carry_adder #(.W(W)) u_rca_c0 (.a(a), .b(b), .cin(1'b0), .s(s_c0), .cout(co_c0));
    ripple_carry_adder #(.W(W)) u_rca_c1 (.a(a), .b(b), .cin(1'b1), .s(s_c1), .cout(co_c1));

    assign s    = sel ? s_c1  : s_c0;
    assign cout = sel ? co_c1 : co_c0;

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain W-bit ripple-carry adder.
module ripple_carry_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int k = 0; k < W; k++) begin
            s[k] = a[k] ^ b[k] ^ c;
            c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        cout = c;
    end

endmodule

// File: rtl/carry_select_subtractor_pipe_32bits.sv
// Pipelined A - B - Bin as A + ~B + ~Bin; one carry-select block per stage,
// the last stage landing directly in the output register.
module carry_select_subtractor_pipe_32bits
    import csel_sub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    carry_select_subtractor_pipe_32bits_if.slave bus
);

    localparam int W0  = blk_w(0);
    localparam int LO1 = blk_lo(1);
    localparam int W1  = blk_w(1);
    localparam int LO2 = blk_lo(2);
    localparam int W2  = blk_w(2);
    localparam int LO3 = blk_lo(3);
    localparam int W3  = blk_w(3);

    stage_t           stage_p0, stage_p1, stage_p2;
    stage_t           nxt_p0, nxt_p1, nxt_p2;
    logic             vld_p3;
    logic [WIDTH-1:0] d_p3;
    logic             bout_p3, z_p3, v_p3;
    logic             adv;

    logic [W0-1:0]    s0;
    logic [W1-1:0]    s1;
    logic [W2-1:0]    s2;
    logic [W3-1:0]    s3;
    logic             c0, c1, c2, c3;
    logic [WIDTH-1:0] d_full;

    assign adv          = !vld_p3 || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 0: low block, borrow-in folded into the carry-in
    ripple_carry_adder #(.W(W0)) u_rca0 (
        .a(bus.A[W0-1:0]), .b(~bus.B[W0-1:0]), .cin(~bus.Bin), .s(s0), .cout(c0)
    );

    always_comb begin
        nxt_p0              = '0;
        nxt_p0.valid        = bus.in_valid;
        nxt_p0.d[W0-1:0]    = s0;
        nxt_p0.carry        = c0;
        nxt_p0.a_rem        = bus.A;
        nxt_p0.a_rem[W0-1:0]  = '0;
        nxt_p0.nb_rem       = ~bus.B;
        nxt_p0.nb_rem[W0-1:0] = '0;
        nxt_p0.a_msb        = bus.A[WIDTH-1];
        nxt_p0.b_msb        = bus.B[WIDTH-1];
    end

    // Stage 1
    csel_block #(.W(W1)) u_blk1 (
        .a(stage_p0.a_rem[LO1 +: W1]), .b(stage_p0.nb_rem[LO1 +: W1]),
        .sel(stage_p0.carry), .s(s1), .cout(c1)
    );

    always_comb begin
        nxt_p1                    = stage_p0;
        nxt_p1.d[LO1 +: W1]       = s1;
        nxt_p1.carry              = c1;
        nxt_p1.a_rem[LO1 +: W1]   = '0;
        nxt_p1.nb_rem[LO1 +: W1]  = '0;
    end

    // Stage 2
    csel_block #(.W(W2)) u_blk2 (
        .a(stage_p1.a_rem[LO2 +: W2]), .b(stage_p1.nb_rem[LO2 +: W2]),
        .sel(stage_p1.carry), .s(s2), .cout(c2)
    );

    always_comb begin
        nxt_p2                    = stage_p1;
        nxt_p2.d[LO2 +: W2]       = s2;
        nxt_p2.carry              = c2;
        nxt_p2.a_rem[LO2 +: W2]   = '0;
        nxt_p2.nb_rem[LO2 +: W2]  = '0;
    end

    // Stage 3: top block resolves into the output register with the flags
    csel_block #(.W(W3)) u_blk3 (
        .a(stage_p2.a_rem[LO3 +: W3]), .b(stage_p2.nb_rem[LO3 +: W3]),
        .sel(stage_p2.carry), .s(s3), .cout(c3)
    );

    always_comb begin
        d_full              = stage_p2.d;
        d_full[LO3 +: W3]   = s3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_p0.valid <= 1'b0;
            stage_p1.valid <= 1'b0;
            stage_p2.valid <= 1'b0;
            vld_p3         <= 1'b0;
            d_p3           <= '0;
            bout_p3        <= 1'b0;
            z_p3           <= 1'b0;
            v_p3           <= 1'b0;
        end else if (adv) begin
            stage_p0 <= nxt_p0;
            stage_p1 <= nxt_p1;
            stage_p2 <= nxt_p2;
            vld_p3   <= stage_p2.valid;
            if (stage_p2.valid) begin
                d_p3    <= d_full;
                bout_p3 <= ~c3;
                z_p3    <= (d_full == '0);
                v_p3    <= (stage_p2.a_msb != stage_p2.b_msb) &&
                           (d_full[WIDTH-1] != stage_p2.a_msb);
            end
        end
    end

    assign bus.out_valid = vld_p3;
    assign bus.D         = d_p3;
    assign bus.Bout      = bout_p3;
    assign bus.Z         = z_p3;
    assign bus.V         = v_p3;

endmodule

// File: doc/carry_select_subtractor_pipe_32bits.md
Name: carry_select_subtractor_pipe_32bits

Overview:
- Pipelined 32-bit subtractor, the inverse-direction counterpart to the team's carry-select adders.
- Computes D = A − B − Bin as A + ~B + ~Bin.
- Uses the same non-uniform carry-select block partition, with block boundaries 4, 10, 20 and 32.
- One block is resolved per pipeline stage, with a valid/ready handshake on both sides. It feeds the ALU flag logic and chained wide subtractions.

Parameters:
- WIDTH, 32, operand width. Must equal the last entry of BLOCKS.
- BLOCK_AMOUNT, 4, number of carry-select blocks, which is also the number of pipeline stages.
- BLOCKS, '{4,10,20,32}, cumulative upper bit boundary of each block. Block i covers bits [BLOCKS[i]-1 : BLOCKS[i-1]], and block 0 covers [3:0].

Ports:
- clk  in  1  single clock; all state on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  subtractor can accept a beat this cycle
- A  in  WIDTH  minuend
- B  in  WIDTH  subtrahend
- Bin  in  1  borrow in (1 = subtract one more)
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- D  out  WIDTH  difference A − B − Bin, modulo 2^WIDTH
- Bout  out  1  borrow out: 1 when unsigned A < B + Bin (inverse of the final carry)
- Z  out  1  D == 0
- V  out  1  signed overflow: (A[31] != B[31]) && (D[31] != A[31])

Behaviour:
- Reset (rst=1 at an edge):
  - all stage valid bits cleared, out_valid=0;
  - D, Bout, Z, V = 0;
  - in-flight beats are discarded, with no partial output;
  - in_ready is 1 in the cycle after reset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_ready and registered state.
- Acceptance and stalls:
  - Accept happens when in_valid && in_ready.
  - When adv=0, every stage holds its data and valid bit. No beat is lost or duplicated.
  - Bubbles propagate as valid=0 stages and are not compressed.
- Stage 0 (on accept):
  - RCA on bits [3:0] with Cin = ~Bin;
  - registers partial D[3:0], carry c0, the remaining operand bits A[31:4] and ~B[31:4], and A[31]/B[31] for V.
- Stage i (1..3):
  - two RCAs over block i, with Cin=0 and Cin=1;
  - a mux selects by the registered carry from stage i−1;
  - the lower result bits already computed are carried forward unchanged;
  - unused upper operand bits are dropped as they are consumed.
- Output register:
  - holds D, Bout = ~carry3, Z and V;
  - latency is 4 cycles from accept to out_valid, with throughput 1 beat/cycle when out_ready=1.
- Handshake boundaries:
  - Simultaneous pop and push (out_valid && out_ready && in_valid) are both accepted in the same cycle; the pipe stays full.
  - out_valid && !out_ready for N cycles: D/Bout/Z/V stay stable and in_ready=0.
  - in_valid may drop at any time without side effects. A and B are ignored when not accepted.
- Arithmetic:
  - wrap-around modulo 2^32;
  - Bin=1 with A=B gives D=0xFFFFFFFF and Bout=1;
  - A=0, B=0, Bin=0 gives Z=1 and Bout=0.

Decomposition:
- Package csel_sub_pkg holds:
  - WIDTH, BLOCK_AMOUNT, the BLOCKS boundary array;
  - a function returning the width of block i;
  - a typedef struct stage_t {valid, partial D, carry, remaining A, remaining ~B, a_msb, b_msb}, used for every pipeline register.
- Sub-module csel_block: a parameterized width, two existing ripple_carry_adder instances (Cin 0/1) and a select mux. It is instantiated for blocks 1..3. Block 0 uses ripple_carry_adder directly.

Test Plan:
- 1. Single beat, not stalled:
  - A=5, B=3, Bin=0, out_ready=1;
  - after exactly 4 cycles: D=2, Bout=0, Z=0, V=0, out_valid for 1 cycle.
- 2. Borrow across every block:
  - A=3, B=5, Bin=0 → D=0xFFFFFFFE, Bout=1, V=0;
  - A=0x00000000, B=0, Bin=1 → D=0xFFFFFFFF, Bout=1.
- 3. Overflow and zero:
  - A=0x80000000, B=1 → D=0x7FFFFFFF, V=1, Bout=0;
  - A=B=0x12345678, Bin=0 → D=0, Z=1, Bout=0.
- 4. Back-to-back stream with backpressure:
  - 8 consecutive beats (A=k*0x1000, B=k), with out_ready held 0 for 3 cycles mid-stream;
  - all 8 results in order with D=k*0xFFF, none lost or duplicated;
  - in_ready=0 exactly while out_valid && !out_ready.
- 5. Reset mid-flight:
  - assert rst for 1 cycle with 3 beats in the pipe;
  - next cycle out_valid=0 and D=0, with no stale beat emerging;
  - a new beat A=10, B=4 yields D=6 after 4 cycles.
- 6. Random reference check:
  - 10k random A/B/Bin with random in_valid/out_ready;
  - every output matches a scoreboard of {Bout,D} = {1'b0,A} − B − Bin (Bout = MSB), plus Z and V.
